matrix_multiply_core3x3_result_reader: RTL and testbench

Receive-side companion to the 3x3 matrix-multiply core: consumes the core's 34-bit `result` element stream, reassembles each three-element output vector (y0, y1, y2), saturates each element to the downstream width, and buffers completed vectors in a small FIFO. Downstream logic reads the vectors over a valid/ready handshake. Sits directly after the core's top entity in the same clock domain.

---
 rtl/matrix_multiply_core3x3_result_reader.sv | 195 +++++++++++++++++++
 tb/tb_matrix_multiply_core3x3_result_reader.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/matrix_multiply_core3x3_result_reader.sv
// Receive-side reader for the 3x3 matrix-multiply core: reassembles {y2,y1,y0}
// vectors from the element stream, saturates each element and queues vectors in a FIFO.
module matrix_multiply_core3x3_result_reader #(
    parameter int ELEM_W = 33,
    parameter int OUT_W  = 32,
    parameter int DEPTH  = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic                 system1000,
    input  logic                 system1000_rstn,
    input  logic [ELEM_W:0]      result,
    input  logic                 frame_start,
    output logic [3*OUT_W-1:0]   out_data,
    output logic [2:0]           out_sat,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LW-1:0]        level,
    output logic                 overflow,
    output logic                 misalign,
    input  logic                 clear_err
);

    localparam int EW = 3*OUT_W + 3;

    typedef enum logic [1:0] {
        IDX_Y0 = 2'd0,
        IDX_Y1 = 2'd1,
        IDX_Y2 = 2'd2
    } idx_t;

    // Returns {sat_flag, value}; in range when all bits above the output sign agree.
    function automatic logic [OUT_W:0] sat_elem(input logic [ELEM_W-1:0] e);
        logic [ELEM_W-OUT_W:0] top;
        top = e[ELEM_W-1:OUT_W-1];
        if ((top == '0) || (top == '1)) begin
            sat_elem = {1'b0, e[OUT_W-1:0]};
        end else if (e[ELEM_W-1] == 1'b0) begin
            sat_elem = {1'b1, 1'b0, {(OUT_W-1){1'b1}}};
        end else begin
            sat_elem = {1'b1, 1'b1, {(OUT_W-1){1'b0}}};
        end
    endfunction

    idx_t               idx_q, idx_d;
    logic [OUT_W:0]     slot0_q, slot0_d;
    logic [OUT_W:0]     slot1_q, slot1_d;
    logic [EW-1:0]      mem_q [DEPTH];
    logic [EW-1:0]      mem_d [DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]      count_q, count_d;
    logic [3*OUT_W-1:0] out_data_q, out_data_d;
    logic [2:0]         out_sat_q, out_sat_d;
    logic               out_valid_q, out_valid_d;
    logic               overflow_q, overflow_d;
    logic               misalign_q, misalign_d;

    logic               elem_valid_s;
    logic [OUT_W:0]     elem_sat_s;
    logic               push_s;
    logic [EW-1:0]      push_vec_s;
    logic               misalign_evt_s;
    logic               overflow_evt_s;
    logic               pop_s;
    logic               full_s;
    logic               push_ok_s;
    logic [EW-1:0]      head_s;

    // Element assembly: track idx, hold y0/y1, emit the completed vector on y2.
    always_comb begin
        idx_d          = idx_q;
        slot0_d        = slot0_q;
        slot1_d        = slot1_q;
        misalign_evt_s = 1'b0;
        push_s         = 1'b0;
        push_vec_s     = '0;
        elem_valid_s   = result[ELEM_W];
        elem_sat_s     = sat_elem(result[ELEM_W-1:0]);
        if (elem_valid_s) begin
            if (frame_start) begin
                misalign_evt_s = (idx_q != IDX_Y0);
                slot0_d        = elem_sat_s;
                idx_d          = IDX_Y1;
            end else begin
                case (idx_q)
                    IDX_Y0: begin
                        slot0_d = elem_sat_s;
                        idx_d   = IDX_Y1;
                    end
                    IDX_Y1: begin
                        slot1_d = elem_sat_s;
                        idx_d   = IDX_Y2;
                    end
                    IDX_Y2: begin
                        push_s     = 1'b1;
                        push_vec_s = {elem_sat_s[OUT_W-1:0], slot1_q[OUT_W-1:0], slot0_q[OUT_W-1:0],
                                      elem_sat_s[OUT_W], slot1_q[OUT_W], slot0_q[OUT_W]};
                        idx_d      = IDX_Y0;
                    end
                    default: begin
                        idx_d = IDX_Y0;
                    end
                endcase
            end
        end else begin
            idx_d = idx_q;
        end
    end

    // FIFO bookkeeping; the output stage is loaded from the post-update head.
    always_comb begin
        mem_d          = mem_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        count_d        = count_q;
        out_data_d     = out_data_q;
        out_sat_d      = out_sat_q;
        pop_s          = out_valid_q & out_ready;
        full_s         = (count_q == LW'(DEPTH));
        push_ok_s      = push_s & (~full_s | pop_s);
        overflow_evt_s = push_s & full_s & ~pop_s;
        if (push_ok_s) begin
            mem_d[wr_ptr_q] = push_vec_s;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_s})
            2'b10:   count_d = count_q + LW'(1);
            2'b01:   count_d = count_q - LW'(1);
            default: count_d = count_q;
        endcase
        head_s      = mem_d[rd_ptr_d];
        out_valid_d = (count_d != '0);
        if (out_valid_d) begin
            out_data_d = head_s[EW-1:3];
            out_sat_d  = head_s[2:0];
        end else begin
            out_data_d = out_data_q;
            out_sat_d  = out_sat_q;
        end
        // A same-cycle new error takes priority over clear_err.
        overflow_d = (overflow_q & ~clear_err) | overflow_evt_s;
        misalign_d = (misalign_q & ~clear_err) | misalign_evt_s;
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            idx_q       <= IDX_Y0;
            slot0_q     <= '0;
            slot1_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_data_q  <= '0;
            out_sat_q   <= 3'b000;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            misalign_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            idx_q       <= idx_d;
            slot0_q     <= slot0_d;
            slot1_q     <= slot1_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
            out_valid_q <= out_valid_d;
            overflow_q  <= overflow_d;
            misalign_q  <= misalign_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;
    assign out_valid = out_valid_q;
    assign level     = count_q;
    assign overflow  = overflow_q;
    assign misalign  = misalign_q;

endmodule

// File: tb/tb_matrix_multiply_core3x3_result_reader.sv
// Directed bench for the result reader: assembly, saturation, FIFO full/drop, misalign and reset.
module tb_matrix_multiply_core3x3_result_reader;

    logic         system1000;
    logic         system1000_rstn;
    logic [33:0]  result;
    logic         frame_start;
    logic [95:0]  out_data;
    logic [2:0]   out_sat;
    logic         out_valid;
    logic         out_ready;
    logic [2:0]   level;
    logic         overflow;
    logic         misalign;
    logic         clear_err;

    int n_tests = 0;
    int n_fail  = 0;

    matrix_multiply_core3x3_result_reader #(
        .ELEM_W(33), .OUT_W(32), .DEPTH(4)
    ) dut (
        .system1000      (system1000),
        .system1000_rstn (system1000_rstn),
        .result          (result),
        .frame_start     (frame_start),
        .out_data        (out_data),
        .out_sat         (out_sat),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .level           (level),
        .overflow        (overflow),
        .misalign        (misalign),
        .clear_err       (clear_err)
    );

    initial system1000 = 1'b0;
    always #5 system1000 = ~system1000;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic fs, input logic [32:0] v);
        result      = {1'b1, v};
        frame_start = fs;
        @(posedge system1000);
        #1;
        result      = 34'd0;
        frame_start = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge system1000);
            #1;
        end
    endtask

    function automatic logic [95:0] vec(input logic [31:0] y0, input logic [31:0] y1, input logic [31:0] y2);
        vec = {y2, y1, y0};
    endfunction

    task automatic send_vec(input int base);
        send(1'b1, 33'(base + 1));
        send(1'b0, 33'(base + 2));
        send(1'b0, 33'(base + 3));
    endtask

    initial begin
        system1000_rstn = 1'b0;
        result          = 34'd0;
        frame_start     = 1'b0;
        out_ready       = 1'b1;
        clear_err       = 1'b0;
        idle(2);
        chk("rst_valid", 128'(out_valid), 128'd0);
        chk("rst_data", 128'(out_data), 128'd0);
        chk("rst_sat", 128'(out_sat), 128'd0);
        chk("rst_level", 128'(level), 128'd0);
        chk("rst_errs", 128'({overflow, misalign}), 128'd0);
        system1000_rstn = 1'b1;
        idle(1);

        // Basic vector, consumed the cycle after it appears
        send(1'b1, 33'h0_0000_0005);
        send(1'b0, 33'h1_FFFF_FFF9);
        chk("partial_no_valid", 128'(out_valid), 128'd0);
        send(1'b0, 33'h0_0000_0010);
        chk("v1_valid", 128'(out_valid), 128'd1);
        chk("v1_data", 128'(out_data), 128'(vec(32'h0000_0005, 32'hFFFF_FFF9, 32'h0000_0010)));
        chk("v1_sat", 128'(out_sat), 128'd0);
        chk("v1_level", 128'(level), 128'd1);
        idle(1);
        chk("v1_popped_level", 128'(level), 128'd0);
        chk("v1_popped_valid", 128'(out_valid), 128'd0);

        // Saturation both directions
        send(1'b1, 33'h0_8000_0000);
        send(1'b0, 33'h1_0000_0000);
        send(1'b0, 33'h0_0000_0003);
        chk("sat_data", 128'(out_data), 128'(vec(32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0003)));
        chk("sat_flags", 128'(out_sat), 128'(3'b011));
        idle(1);

        // Fill the FIFO and overflow it
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send_vec(10 * i);
        end
        chk("full_level", 128'(level), 128'd4);
        chk("ovf_set", 128'(overflow), 128'd1);
        chk("ovf_no_misalign", 128'(misalign), 128'd0);
        idle(2);
        chk("stall_data", 128'(out_data), 128'(vec(32'd1, 32'd2, 32'd3)));
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain%0d", i), 128'(out_data),
                128'(vec(32'(10 * i + 1), 32'(10 * i + 2), 32'(10 * i + 3))));
            idle(1);
        end
        chk("drained_level", 128'(level), 128'd0);
        chk("drained_valid", 128'(out_valid), 128'd0);
        chk("ovf_sticky", 128'(overflow), 128'd1);
        clear_err = 1'b1;
        idle(1);
        clear_err = 1'b0;
        chk("ovf_cleared", 128'(overflow), 128'd0);

        // Misaligned frame_start discards the partial vector
        send(1'b1, 33'd1);
        send(1'b0, 33'd2);
        send(1'b1, 33'd9);
        chk("misalign_set", 128'(misalign), 128'd1);
        chk("misalign_no_out", 128'(out_valid), 128'd0);
        send(1'b0, 33'd8);
        send(1'b0, 33'd7);
        chk("misalign_data", 128'(out_data), 128'(vec(32'd9, 32'd8, 32'd7)));
        chk("misalign_level", 128'(level), 128'd1);
        idle(1);
        chk("misalign_drained", 128'(level), 128'd0);
        clear_err = 1'b1;
        idle(1);
        clear_err = 1'b0;
        chk("misalign_cleared", 128'(misalign), 128'd0);

        // Full FIFO with simultaneous pop and push
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send_vec(100 + 10 * i);
        end
        chk("full2_level", 128'(level), 128'd4);
        send(1'b1, 33'd201);
        send(1'b0, 33'd202);
        out_ready = 1'b1;
        send(1'b0, 33'd203);
        chk("pushpop_level", 128'(level), 128'd4);
        chk("pushpop_ovf", 128'(overflow), 128'd0);
        for (int i = 1; i < 4; i++) begin
            chk($sformatf("pp_drain%0d", i), 128'(out_data),
                128'(vec(32'(100 + 10 * i + 1), 32'(100 + 10 * i + 2), 32'(100 + 10 * i + 3))));
            idle(1);
        end
        chk("pp_last", 128'(out_data), 128'(vec(32'd201, 32'd202, 32'd203)));
        idle(1);
        chk("pp_empty", 128'(level), 128'd0);

        // Asynchronous reset mid-vector with vectors queued
        out_ready = 1'b0;
        send_vec(300);
        send_vec(310);
        send(1'b1, 33'd321);
        send(1'b0, 33'd322);
        chk("prerst_level", 128'(level), 128'd2);
        system1000_rstn = 1'b0;
        #1;
        chk("async_rst_valid", 128'(out_valid), 128'd0);
        chk("async_rst_level", 128'(level), 128'd0);
        chk("async_rst_data", 128'(out_data), 128'd0);
        idle(2);
        #2;
        system1000_rstn = 1'b1;
        out_ready = 1'b1;
        send(1'b0, 33'd4);
        send(1'b0, 33'd5);
        chk("postrst_partial", 128'(out_valid), 128'd0);
        send(1'b0, 33'd6);
        chk("postrst_valid", 128'(out_valid), 128'd1);
        chk("postrst_data", 128'(out_data), 128'(vec(32'd4, 32'd5, 32'd6)));
        chk("postrst_level", 128'(level), 128'd1);
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
